// File: rtl/ex2_mul_combine_if.sv
// EX1->EX2 partial-product handshake bundle and the EX2 result channel.
// master drives partial products and accepts results; slave is the combiner.
interface ex2_mul_combine_if #(
  parameter int unsigned RD_W   = 5,
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_hh;
  logic [DATA_W-1:0] in_hl;
  logic [DATA_W-1:0] in_lh;
  logic [DATA_W-1:0] in_ll;
  logic [DATA_W-1:0] in_comp;
  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_result;

  modport master (
    output in_valid, in_op, in_rd, in_hh, in_hl, in_lh, in_ll, in_comp, out_ready,
    input  in_ready, out_valid, out_rd, out_result
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_hh, in_hl, in_lh, in_ll, in_comp, out_ready,
    output in_ready, out_valid, out_rd, out_result
  );
endinterface

// File: rtl/ex2_mul_combine.sv
// EX2 multiplier combine: reduces EX1 partial products to a 64-bit product and picks the
// MUL.W / MULH.W / MULH.WU word through a two-stage elastic pipeline.
module ex2_mul_combine #(
  parameter int unsigned RD_W   = 5,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               aresetn,
  input logic               flush,
  ex2_mul_combine_if.slave  bus
);

  localparam int unsigned HalfW = DATA_W / 2;
  localparam int unsigned ProdW = 2 * DATA_W;
  localparam logic [1:0]  OpMulH  = 2'b01;
  localparam logic [1:0]  OpMulHU = 2'b10;

  // Stage A
  logic              a_valid_q;
  logic [1:0]        a_op_q;
  logic [RD_W-1:0]   a_rd_q;
  logic [DATA_W-1:0] a_hh_q;
  logic [DATA_W-1:0] a_ll_q;
  logic [DATA_W-1:0] a_comp_q;
  logic [DATA_W:0]   a_mid_q;

  // Stage B doubles as the output register
  logic              b_valid_q;
  logic [RD_W-1:0]   out_rd_q;
  logic [DATA_W-1:0] out_result_q;

  logic              b_adv;
  logic              a_adv;
  logic              in_ready;
  logic              in_fire;
  logic [DATA_W:0]   mid_d;
  logic [ProdW-1:0]  full;
  logic [DATA_W-1:0] result_d;

  always_comb begin
    b_adv    = ~b_valid_q | bus.out_ready;
    a_adv    = a_valid_q & b_adv;
    in_ready = ~a_valid_q | b_adv;
    in_fire  = bus.in_valid & in_ready & ~flush;
    mid_d    = {1'b0, bus.in_hl} + {1'b0, bus.in_lh};
  end

  // Cross terms sit HalfW bits up; the 33-bit mid keeps its carry.
  always_comb begin
    full = {a_hh_q, {DATA_W{1'b0}}}
         + {{(DATA_W - HalfW - 1){1'b0}}, a_mid_q, {HalfW{1'b0}}}
         + {{DATA_W{1'b0}}, a_ll_q};
    case (a_op_q)
      OpMulH:  result_d = full[ProdW-1:DATA_W] - a_comp_q;
      OpMulHU: result_d = full[ProdW-1:DATA_W];
      default: result_d = full[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      out_rd_q     <= '0;
      out_result_q <= '0;
    end else if (flush) begin
      // Output data is left untouched so an empty stage keeps its last value.
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      if (b_adv) begin
        b_valid_q <= a_valid_q;
      end
      if (a_adv) begin
        out_rd_q     <= a_rd_q;
        out_result_q <= result_d;
      end
      if (in_ready) begin
        a_valid_q <= bus.in_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_op_q   <= bus.in_op;
      a_rd_q   <= bus.in_rd;
      a_hh_q   <= bus.in_hh;
      a_ll_q   <= bus.in_ll;
      a_comp_q <= bus.in_comp;
      a_mid_q  <= mid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = b_valid_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_result = out_result_q;

endmodule

// File: tb/tb_ex2_mul_combine.sv
// Bench for ex2_mul_combine: operands are multiplied in plain 64-bit arithmetic as the
// reference and split into EX1-style partial products to drive the block.
module tb_ex2_mul_combine;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  logic clk;
  logic aresetn;
  logic flush;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];

  logic        s_acc, s_pop, s_vld, s_rdy;
  logic [4:0]  s_rd;
  logic [31:0] s_res;

  ex2_mul_combine_if #(.RD_W(5), .DATA_W(32)) bus ();

  ex2_mul_combine #(.RD_W(5), .DATA_W(32)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    case (op)
      2'b01:   return sp[63:32];
      2'b10:   return up[63:32];
      default: return up[31:0];
    endcase
  endfunction

  // Drive one cycle, sample at the falling edge, return just after the next rising edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic ordy,
                      input logic fl);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_hh     = {16'b0, a[31:16]} * {16'b0, b[31:16]};
    bus.in_hl     = {16'b0, a[31:16]} * {16'b0, b[15:0]};
    bus.in_lh     = {16'b0, a[15:0]} * {16'b0, b[31:16]};
    bus.in_ll     = {16'b0, a[15:0]} * {16'b0, b[15:0]};
    bus.in_comp   = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    s_rdy = bus.in_ready;
    s_vld = bus.out_valid;
    s_rd  = bus.out_rd;
    s_res = bus.out_result;
    s_acc = v & s_rdy;
    s_pop = s_vld & ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    flush   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    n_cmp++;
    if ({bus.out_valid, bus.out_rd, bus.out_result} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b rd=%0d res=%h, required 0/0/0",
               bus.out_valid, bus.out_rd, bus.out_result);
    end
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1);
    n_cmp++;
    if (s_rdy !== 1'b1 || s_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0", s_rdy, s_vld);
    end
  endtask

  task automatic test_directed();
    step(1'b1, 2'b01, 32'hFFFF_FFFD, 32'd5, 5'd3, 1'b1, 1'b0);
    n_cmp++;
    if (s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_accept: got in_ready=%b, required 1", s_rdy);
    end
    step(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5, 5'd4, 1'b1, 1'b0);
    n_cmp++;
    if (s_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_latency_n1: got out_valid=%b, required 0", s_vld);
    end
    idle(1'b1);
    n_cmp++;
    if ({s_vld, s_rd, s_res} !== {1'b1, 5'd3, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL dir_mulh_neg: got vld=%b rd=%0d res=%h, required 1/3/ffffffff",
               s_vld, s_rd, s_res);
    end
    idle(1'b1);
    n_cmp++;
    if ({s_vld, s_rd, s_res} !== {1'b1, 5'd4, 32'hFFFF_FFF1}) begin
      n_fail++;
      $display("FAIL dir_mul_neg: got vld=%b rd=%0d res=%h, required 1/4/fffffff1",
               s_vld, s_rd, s_res);
    end
    step(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 1'b0);
    step(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0);
    idle(1'b1);
    n_cmp++;
    if ({s_vld, s_rd, s_res} !== {1'b1, 5'd6, 32'hFFFF_FFFE}) begin
      n_fail++;
      $display("FAIL dir_mulhu_max: got vld=%b rd=%0d res=%h, required 1/6/fffffffe",
               s_vld, s_rd, s_res);
    end
    idle(1'b1);
    n_cmp++;
    if ({s_vld, s_rd, s_res} !== {1'b1, 5'd7, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL dir_mulh_max: got vld=%b rd=%0d res=%h, required 1/7/00000000",
               s_vld, s_rd, s_res);
    end
    idle(1'b1);
    n_cmp++;
    if (s_vld !== 1'b0 || s_res !== 32'h0) begin
      n_fail++;
      $display("FAIL dir_empty_hold: got vld=%b res=%h, required 0/00000000", s_vld, s_res);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] a, b;
    logic [1:0]  op;
    int          first, last, cyc, naccept;
    first = -1; last = -1; cyc = 0; naccept = 0;
    for (int i = 0; i < 40 && (i < 10 || exp_q.size() != 0); i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      if (i < 10) step(1'b1, op, a, b, 5'(i + 10), 1'b1, 1'b0);
      else        idle(1'b1);
      if (s_pop) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got rd=%0d res=%h, required no output", s_rd, s_res);
        end else begin
          e = exp_q.pop_front();
          if ({s_rd, s_res} !== {e.rd, e.res}) begin
            n_fail++;
            $display("FAIL b2b_data: got rd=%0d res=%h, required rd=%0d res=%h",
                     s_rd, s_res, e.rd, e.res);
          end
        end
      end
      if (i < 10 && s_acc) begin
        naccept++;
        exp_q.push_back('{rd: 5'(i + 10), res: ref_res(op, a, b)});
      end
      cyc++;
    end
    n_cmp++;
    if (naccept != 10 || last - first != 9 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_stream: got accepts=%0d span=%0d left=%0d, required 10/9/0",
               naccept, last - first, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [31:0] a, b, held;
    logic [1:0]  op;
    logic [4:0]  rd;
    int          naccept, npop;
    naccept = 0; npop = 0; held = '0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); rd = 5'd20;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, op, a, b, rd, 1'b0, 1'b0);
      n_cmp++;
      if (s_rdy !== (i < 2)) begin
        n_fail++;
        $display("FAIL bp_in_ready[%0d]: got %b, required %b", i, s_rdy, i < 2);
      end
      if (i == 2) held = s_res;
      if (i > 2) begin
        n_cmp++;
        if (s_vld !== 1'b1 || s_res !== held) begin
          n_fail++;
          $display("FAIL bp_stable[%0d]: got vld=%b res=%h, required 1/%h", i, s_vld, s_res,
                   held);
        end
      end
      if (s_acc) begin
        naccept++;
        exp_q.push_back('{rd: rd, res: ref_res(op, a, b)});
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); rd = rd + 5'd1;
      end
    end
    n_cmp++;
    if (naccept != 2) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d, required 2", naccept);
    end
    for (int i = 0; i < 30 && (naccept < 3 || exp_q.size() != 0); i++) begin
      step(naccept < 3, op, a, b, rd, 1'b1, 1'b0);
      if (s_pop) begin
        npop++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got rd=%0d res=%h, required no output", s_rd, s_res);
        end else begin
          e = exp_q.pop_front();
          if ({s_rd, s_res} !== {e.rd, e.res}) begin
            n_fail++;
            $display("FAIL bp_data: got rd=%0d res=%h, required rd=%0d res=%h",
                     s_rd, s_res, e.rd, e.res);
          end
        end
      end
      if (s_acc && naccept < 3) begin
        naccept++;
        exp_q.push_back('{rd: rd, res: ref_res(op, a, b)});
      end
    end
    n_cmp++;
    if (npop != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got pops=%0d left=%0d, required 3/0", npop, exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    step(1'b1, 2'b00, a, b, 5'd21, 1'b0, 1'b0);
    step(1'b1, 2'b00, a, b, 5'd22, 1'b0, 1'b0);
    step(1'b1, 2'b00, a, b, 5'd23, 1'b0, 1'b1);
    n_cmp++;
    if (s_rdy !== 1'b0 || s_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got in_ready=%b out_valid=%b, required 0/1", s_rdy, s_vld);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_cmp++;
      if (s_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_full_clear[%0d]: got out_valid=%b rd=%0d, required 0", i, s_vld,
                 s_rd);
      end
    end
    // Output handshake in the flush cycle completes; the op behind it does not.
    step(1'b1, 2'b01, a, b, 5'd26, 1'b1, 1'b0);
    step(1'b1, 2'b01, a, b, 5'd27, 1'b1, 1'b0);
    step(1'b1, 2'b01, a, b, 5'd28, 1'b1, 1'b1);
    n_cmp++;
    if ({s_vld, s_rdy, s_rd, s_res} !== {1'b1, 1'b1, 5'd26, ref_res(2'b01, a, b)}) begin
      n_fail++;
      $display("FAIL flush_out_hs: got vld=%b rdy=%b rd=%0d res=%h, required 1/1/26/%h",
               s_vld, s_rdy, s_rd, s_res, ref_res(2'b01, a, b));
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_cmp++;
      if (s_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drop[%0d]: got out_valid=%b rd=%0d, required 0", i, s_vld, s_rd);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] a, b;
    a = $urandom | 32'h1; b = $urandom | 32'h1;
    step(1'b1, 2'b00, a, b, 5'd11, 1'b0, 1'b0);
    step(1'b1, 2'b00, a, b, 5'd12, 1'b0, 1'b0);
    step(1'b1, 2'b00, a, b, 5'd13, 1'b0, 1'b0);
    #2;
    bus.in_valid = 1'b0;
    aresetn      = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_rd, bus.out_result} !== 38'd0) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b rd=%0d res=%h, required 0/0/0",
               bus.out_valid, bus.out_rd, bus.out_result);
    end
    @(posedge clk);
    #3;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    a = $urandom; b = $urandom;
    step(1'b1, 2'b10, a, b, 5'd9, 1'b1, 1'b0);
    n_cmp++;
    if (s_rdy !== 1'b1 || s_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b, required 1/0", s_rdy,
               s_vld);
    end
    idle(1'b1);
    n_cmp++;
    if (s_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_n1: got out_valid=%b, required 0", s_vld);
    end
    idle(1'b1);
    n_cmp++;
    if ({s_vld, s_rd, s_res} !== {1'b1, 5'd9, ref_res(2'b10, a, b)}) begin
      n_fail++;
      $display("FAIL post_reset_n2: got vld=%b rd=%0d res=%h, required 1/9/%h", s_vld, s_rd,
               s_res, ref_res(2'b10, a, b));
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic        p_v, ordy, fl, exp_rdy;
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [4:0]  rd;
    p_v = 1'b0; a = '0; b = '0; op = '0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_v && ($urandom % 4 != 0) && i < 360) begin
        p_v = 1'b1;
        a   = $urandom;
        b   = $urandom;
        op  = 2'($urandom_range(0, 3));
        rd  = 5'($urandom);
      end
      ordy = (i >= 360) || ($urandom % 3 != 0);
      fl   = (i < 360) && ($urandom % 32 == 0);
      step(p_v, op, a, b, rd, ordy, fl);
      exp_rdy = !(exp_q.size() == 2 && !ordy);
      n_cmp++;
      if (s_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_in_ready[%0d]: got %b, required %b", i, s_rdy, exp_rdy);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        if (s_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_empty[%0d]: got out_valid=%b, required 0", i, s_vld);
        end
      end
      if (s_pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra[%0d]: got rd=%0d res=%h, required no output", i, s_rd,
                   s_res);
        end else begin
          e = exp_q.pop_front();
          if ({s_rd, s_res} !== {e.rd, e.res}) begin
            n_fail++;
            $display("FAIL rnd_data[%0d]: got rd=%0d res=%h, required rd=%0d res=%h", i,
                     s_rd, s_res, e.rd, e.res);
          end
        end
      end
      if (fl) begin
        exp_q.delete();
        p_v = 1'b0;
      end else if (s_acc) begin
        exp_q.push_back('{rd: rd, res: ref_res(op, a, b)});
        p_v = 1'b0;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
